// File: rtl/parity_pkg.sv
// Shared parity constants: parity sense selectors and default word width.
// Imported by parity blocks that want a common meaning for ODD_PARITY.
package parity_pkg;

  localparam int unsigned PARITY_EVEN   = 0;
  localparam int unsigned PARITY_ODD    = 1;
  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/parity_tree.sv
// Balanced combinational XOR-reduction tree.
// Ports: data_i word in, par_o = ^data_i.
module parity_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             par_o
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int LEAVES = 1 << LEVELS;
  localparam int NODES  = 2 * LEAVES - 1;

  // Heap-ordered tree: node k has children 2k+1 and 2k+2,
  // leaves occupy the last LEAVES slots, root is node 0.
  logic node [NODES];

  genvar j, l, i;

  for (j = 0; j < LEAVES; j++) begin : g_leaf
    if (j < WIDTH) begin : g_in
      assign node[LEAVES-1+j] = data_i[j];
    end else begin : g_pad
      assign node[LEAVES-1+j] = 1'b0;
    end
  end

  for (l = 0; l < LEVELS; l++) begin : g_lvl
    for (i = 0; i < (1 << l); i++) begin : g_node
      localparam int K = (1 << l) - 1 + i;
      assign node[K] = node[2*K+1] ^ node[2*K+2];
    end
  end

  assign par_o = node[0];

endmodule

// File: rtl/parity_checker.sv
// Registered parity checker: samples data on check, result on res next clock.
// Ports: clk, rst_n (sync, active-low), check strobe, data word, res.
module parity_checker
  import parity_pkg::*;
#(
  parameter int          DATA_WIDTH = DEFAULT_WIDTH,
  parameter int unsigned ODD_PARITY = PARITY_EVEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  check,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  res
);

  localparam logic INVERT = (ODD_PARITY != PARITY_EVEN);

  logic par;
  logic res_d;
  logic res_q;

  parity_tree #(
    .WIDTH (DATA_WIDTH)
  ) u_tree (
    .data_i (data),
    .par_o  (par)
  );

  always_comb begin
    res_d = res_q;
    if (check) begin
      res_d = par ^ INVERT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 1'b0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_parity_checker.sv
// Self-checking bench for parity_checker.
// Covers reset, directed bytes, hold, back-to-back, reset priority, params.
module tb_parity_checker;

  logic clk;
  logic rst_n;

  logic       chk8;
  logic [7:0] d8;
  logic       res8;

  logic       chko;
  logic [7:0] dodd;
  logic       reso;

  logic       chk1;
  logic [0:0] d1;
  logic       res1;

  logic        chk13;
  logic [12:0] d13;
  logic        res13;

  int checks;
  int errors;

  parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst_n(rst_n), .check(chk8), .data(d8), .res(res8)
  );

  parity_checker #(.DATA_WIDTH(8), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .check(chko), .data(dodd), .res(reso)
  );

  parity_checker #(.DATA_WIDTH(1), .ODD_PARITY(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .check(chk1), .data(d1), .res(res1)
  );

  parity_checker #(.DATA_WIDTH(13), .ODD_PARITY(0)) u_w13 (
    .clk(clk), .rst_n(rst_n), .check(chk13), .data(d13), .res(res13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic ref_par(input logic [31:0] v, input int w);
    int ones;
    ones = 0;
    for (int k = 0; k < w; k++) begin
      if (v[k]) ones++;
    end
    return (ones % 2) == 1;
  endfunction

  initial begin
    logic [31:0] r;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'b00000001, 1'b1};
    vecs[1] = '{8'b01000001, 1'b0};
    vecs[2] = '{8'b00110001, 1'b1};
    vecs[3] = '{8'b11110001, 1'b1};
    vecs[4] = '{8'b00110111, 1'b1};
    vecs[5] = '{8'b00000000, 1'b0};
    vecs[6] = '{8'b11111111, 1'b0};
    vecs[7] = '{8'b00000001, 1'b1};

    rst_n = 1'b0;
    chk8  = 1'b0; d8   = '0;
    chko  = 1'b0; dodd = '0;
    chk1  = 1'b0; d1   = '0;
    chk13 = 1'b0; d13  = '0;
    @(negedge clk);

    // reset
    step();
    chk("reset_even", res8, 1'b0);
    chk("reset_odd", reso, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", res8, 1'b0);

    // directed table
    for (int v = 0; v < 8; v++) begin
      d8   = vecs[v].data;
      chk8 = 1'b1;
      step();
      chk($sformatf("vec%0d", v), res8, vecs[v].exp);
      chk8 = 1'b0;
      d8   = ~vecs[v].data;
      step();
      chk($sformatf("vec%0d_hold", v), res8, vecs[v].exp);
    end

    // hold with changing data
    d8   = 8'b00000001;
    chk8 = 1'b1;
    step();
    chk("hold_strobe", res8, 1'b1);
    chk8 = 1'b0;
    d8   = 8'b00000011;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("hold_c%0d", c), res8, 1'b1);
    end

    // back-to-back
    chk8 = 1'b1;
    d8   = 8'b00000001;
    step();
    chk("b2b_0", res8, 1'b1);
    d8 = 8'b00000011;
    step();
    chk("b2b_1", res8, 1'b0);
    d8 = 8'b00000111;
    step();
    chk("b2b_2", res8, 1'b1);
    chk8 = 1'b0;

    // reset beats a simultaneous strobe
    rst_n = 1'b0;
    chk8  = 1'b1;
    d8    = 8'b00000001;
    step();
    chk("rst_priority", res8, 1'b0);
    rst_n = 1'b1;
    chk8  = 1'b0;
    step();
    chk("rst_priority_after", res8, 1'b0);

    // odd parity sense
    chko = 1'b1;
    dodd = 8'b00000000;
    step();
    chk("odd_zero", reso, 1'b1);
    dodd = 8'b00000001;
    step();
    chk("odd_one", reso, 1'b0);
    dodd = 8'b11111111;
    step();
    chk("odd_ones", reso, 1'b1);
    chko = 1'b0;

    // width sweep against reference model
    chk1  = 1'b1;
    chk13 = 1'b1;
    for (int n = 0; n < 24; n++) begin
      r   = $urandom;
      d1  = r[0:0];
      d13 = r[20:8];
      step();
      chk($sformatf("w1_%0d", n), res1, ref_par({31'd0, r[0]}, 1));
      chk($sformatf("w13_%0d", n), res13,
          ref_par({19'd0, r[20:8]}, 13));
    end
    chk1  = 1'b0;
    chk13 = 1'b0;

    // all-ones 13-bit: odd count
    chk13 = 1'b1;
    d13   = '1;
    step();
    chk("w13_ones", res13, 1'b1);
    chk13 = 1'b0;
    d13   = '0;
    step();
    chk("w13_ones_hold", res13, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
